interrupt_controller: RTL and testbench
=======================================

INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

Interface
REQ-001 Parameter NUM_SRC, default 4, number of interrupt sources (legal 1..8).
REQ-002 Parameter VECTOR_BASE, default 32'd1024, handler address of source 0.
REQ-003 Parameter VECTOR_STRIDE, default 32'd16, address spacing between source handlers.
REQ-004 Parameter FLUSH_CYCLES, default 3, pipeline drain length in cycles (legal 1..7).
REQ-005 clk  in  1  clock; all state updates on its rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 irq_src  in  NUM_SRC  raw interrupt request lines.
REQ-008 irq_en  in  NUM_SRC  per-source enable.
REQ-009 global_mask  in  1  high blocks acceptance of new interrupts.
REQ-010 stall  in  1  next-PC stage stalled; vector redirect must wait.
REQ-011 epc_in  in  32  PC of oldest unretired instruction, captured as return address.
REQ-012 rti  in  1  return-from-interrupt decoded.
REQ-013 flush  out  1  flush fetch/decode while draining.
REQ-014 take_vector  out  1  one-cycle strobe: next PC = vector_pc.
REQ-015 vector_pc  out  32  handler address of active source.
REQ-016 ret_take  out  1  one-cycle strobe: next PC = epc_out.
REQ-017 epc_out  out  32  saved return address.
REQ-018 irq_ack  out  NUM_SRC  one-hot acknowledge, valid with take_vector only.
REQ-019 active_id  out  3  index of accepted source.
REQ-020 in_service  out  1  handler running.

Function
REQ-021 States IDLE, DRAIN, VECTOR, SERVICE; 3-bit drain counter.
REQ-022 eligible = pending & irq_en; a request exists when eligible is nonzero and global_mask is low.
REQ-023 Fixed priority: lowest eligible index wins.
REQ-024 IDLE: on request, latch winner into active_id, clear counter, go DRAIN next cycle.
REQ-025 DRAIN: flush=1; counter increments each cycle; after exactly FLUSH_CYCLES DRAIN cycles go VECTOR.
REQ-026 DRAIN is committed: deasserting irq_src/irq_en or raising global_mask does not abort it.
REQ-027 VECTOR: take_vector=1 and irq_ack[active_id]=1 only while stall=0; stall=1 holds VECTOR with both low.
REQ-028 On the take_vector cycle latch epc_out<=epc_in and go SERVICE.
REQ-029 vector_pc = VECTOR_BASE + active_id*VECTOR_STRIDE, 32-bit modulo, combinational from active_id.
REQ-030 SERVICE: in_service=1; new requests are held pending, not accepted; rti gives ret_take=1 for that cycle and IDLE next cycle.
REQ-031 rti outside SERVICE ignored; ret_take and take_vector never assert together.
REQ-032 In IDLE on the cycle after SERVICE, a pending request is accepted immediately (back-to-back).
REQ-033 flush, take_vector, ret_take, irq_ack, in_service are zero in states not listed above.

Reset
REQ-034 rst_n low: state IDLE, counter 0, active_id 0, epc_out 0, pending 0, edge-history 0; all outputs 0 except vector_pc=VECTOR_BASE.
REQ-035 Reset mid-DRAIN/VECTOR/SERVICE aborts with no ack or strobe; first acceptance earliest one cycle after rst_n rises.

Configuration
REQ-036 Macro IRQ_EDGE_CAPTURE_EN defined: pending[i] set on a rising edge of irq_src[i] (vs. previous-cycle sample), cleared by irq_ack[i]; set wins over simultaneous clear.
REQ-037 IRQ_EDGE_CAPTURE_EN undefined: pending = irq_src (level); no internal clear, the source must drop its line.

Verification
REQ-038 Defaults, irq_src=4'b0100, irq_en=4'hF, epc_in=32'h200 -> flush high 3 cycles, then take_vector with vector_pc=32'h420, irq_ack=4'b0100, epc_out=32'h200.
REQ-039 irq_src=4'b1010 simultaneous -> active_id=1, vector_pc=32'h410; source 3 taken after rti, back-to-back, vector 32'h430.
REQ-040 stall=1 for 2 cycles in VECTOR -> take_vector delayed 2 cycles, single ack pulse, epc captured on take cycle.
REQ-041 global_mask=1 with pending source -> no flush; mask drop -> DRAIN begins next cycle; mask raised mid-DRAIN -> sequence completes.
REQ-042 rti in SERVICE with epc_out=32'h200 -> ret_take=1 one cycle, in_service drops; rti in IDLE -> no response.
REQ-043 rst_n low during DRAIN cycle 2 -> all outputs zero, no ack; edge build: source pulse held through SERVICE is taken once.

Source files
------------

// File: rtl/interrupt_controller.sv
// Vectored interrupt controller: drains the pipeline, redirects to a per-source handler, returns on rti.
// Define IRQ_EDGE_CAPTURE_EN for rising-edge latched requests; the default build uses level requests.
module interrupt_controller #(
  parameter int          NUM_SRC       = 4,
  parameter logic [31:0] VECTOR_BASE   = 32'd1024,
  parameter logic [31:0] VECTOR_STRIDE = 32'd16,
  parameter int          FLUSH_CYCLES  = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic [NUM_SRC-1:0] irq_en,
  input  logic               global_mask,
  input  logic               stall,
  input  logic [31:0]        epc_in,
  input  logic               rti,
  output logic               flush,
  output logic               take_vector,
  output logic [31:0]        vector_pc,
  output logic               ret_take,
  output logic [31:0]        epc_out,
  output logic [NUM_SRC-1:0] irq_ack,
  output logic [2:0]         active_id,
  output logic               in_service
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] DRAIN   = 2'd1;
  localparam logic [1:0] VECTOR  = 2'd2;
  localparam logic [1:0] SERVICE = 2'd3;

  logic [1:0]         state_reg, state_next;
  logic [2:0]         cnt_reg, cnt_next;
  logic [2:0]         active_id_reg, active_id_next;
  logic [31:0]        epc_reg, epc_next;
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] eligible;
  logic               request;
  logic [2:0]         winner;

`ifdef IRQ_EDGE_CAPTURE_EN
  logic [NUM_SRC-1:0] pending_reg;
  logic [NUM_SRC-1:0] prev_reg;

  // A new edge in the same cycle as its acknowledge keeps the request pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_reg <= '0;
      prev_reg    <= '0;
    end else begin
      prev_reg    <= irq_src;
      pending_reg <= (pending_reg & ~irq_ack) | (irq_src & ~prev_reg);
    end
  end

  assign pending = pending_reg;
`else
  assign pending = irq_src;
`endif

  assign eligible = pending & irq_en;
  assign request  = (|eligible) && !global_mask;

  always_comb begin
    winner = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) winner = 3'(i);
    end
  end

  assign flush       = (state_reg == DRAIN);
  assign take_vector = (state_reg == VECTOR) && !stall;
  assign ret_take    = (state_reg == SERVICE) && rti;
  assign in_service  = (state_reg == SERVICE);
  assign active_id   = active_id_reg;
  assign epc_out     = epc_reg;
  assign vector_pc   = VECTOR_BASE + 32'(active_id_reg) * VECTOR_STRIDE;

  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_ack
      assign irq_ack[gi] = take_vector && (active_id_reg == 3'(gi));
    end
  endgenerate

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    active_id_next = active_id_reg;
    epc_next       = epc_reg;
    case (state_reg)
      IDLE: begin
        if (request) begin
          active_id_next = winner;
          cnt_next       = '0;
          state_next     = DRAIN;
        end
      end
      DRAIN: begin
        // Committed once entered: inputs cannot abort the drain.
        cnt_next = cnt_reg + 3'd1;
        if (cnt_reg == 3'(FLUSH_CYCLES - 1)) state_next = VECTOR;
      end
      VECTOR: begin
        if (!stall) begin
          epc_next   = epc_in;
          state_next = SERVICE;
        end
      end
      SERVICE: begin
        if (rti) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      active_id_reg <= '0;
      epc_reg       <= '0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      active_id_reg <= active_id_next;
      epc_reg       <= epc_next;
    end
  end

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller; expected vector events are queued at stimulus time
// and popped when take_vector strobes.
module tb_interrupt_controller;

`ifdef IRQ_EDGE_CAPTURE_EN
  localparam int EDGE_LAT = 1;
`else
  localparam int EDGE_LAT = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  irq_src = '0;
  logic [3:0]  irq_en = '0;
  logic        global_mask = 1'b0;
  logic        stall = 1'b0;
  logic [31:0] epc_in = '0;
  logic        rti = 1'b0;
  logic        flush, take_vector, ret_take, in_service;
  logic [31:0] vector_pc, epc_out;
  logic [3:0]  irq_ack;
  logic [2:0]  active_id;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0]  id;
    logic [31:0] pc;
    logic [3:0]  ack;
    logic [31:0] epc;
  } exp_t;

  exp_t sb[$];
  exp_t cur;

  interrupt_controller dut (
    .clk(clk), .rst_n(rst_n), .irq_src(irq_src), .irq_en(irq_en),
    .global_mask(global_mask), .stall(stall), .epc_in(epc_in), .rti(rti),
    .flush(flush), .take_vector(take_vector), .vector_pc(vector_pc),
    .ret_take(ret_take), .epc_out(epc_out), .irq_ack(irq_ack),
    .active_id(active_id), .in_service(in_service)
  );

  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Waits for the vector strobe, compares it against the oldest queued event, reports cycles waited.
  task automatic wait_take(input string tag, output int n);
    n = 0;
    while (!take_vector && n < 20) begin
      cycle();
      n++;
    end
    chk({tag, "_take_seen"}, 32'(take_vector), 32'd1);
    if (take_vector) begin
      if (sb.size() == 0) begin
        chk({tag, "_unexpected_take"}, 32'(sb.size()), 32'd1);
      end else begin
        cur = sb.pop_front();
        chk({tag, "_active_id"}, 32'(active_id), 32'(cur.id));
        chk({tag, "_vector_pc"}, vector_pc, cur.pc);
        chk({tag, "_irq_ack"}, 32'(irq_ack), 32'(cur.ack));
        chk({tag, "_no_ret"}, 32'(ret_take), 32'd0);
        cycle();
        chk({tag, "_epc_out"}, epc_out, cur.epc);
        chk({tag, "_in_service"}, 32'(in_service), 32'd1);
        chk({tag, "_ack_single"}, 32'(irq_ack), 32'd0);
      end
    end
  endtask

  task automatic do_rti(input string tag);
    rti = 1'b1;
    #1;
    chk({tag, "_ret_take"}, 32'(ret_take), 32'd1);
    chk({tag, "_ret_no_vec"}, 32'(take_vector), 32'd0);
    cycle();
    rti = 1'b0;
    #1;
    chk({tag, "_in_service_drop"}, 32'(in_service), 32'd0);
    chk({tag, "_ret_one_cycle"}, 32'(ret_take), 32'd0);
  endtask

  initial begin
    int n;
    // Reset state
    repeat (2) cycle();
    chk("rst_flush", 32'(flush), 32'd0);
    chk("rst_take", 32'(take_vector), 32'd0);
    chk("rst_ack", 32'(irq_ack), 32'd0);
    chk("rst_vector_pc", vector_pc, 32'h400);
    chk("rst_epc", epc_out, 32'd0);
    chk("rst_active_id", 32'(active_id), 32'd0);
    rst_n = 1'b1;
    cycle();

    // Single source 2: three drain cycles then vector 0x420
    irq_en = 4'hF;
    epc_in = 32'h200;
    irq_src = 4'b0100;
    sb.push_back('{3'd2, 32'h420, 4'b0100, 32'h200});
    #1;
    chk("t1_idle_flush", 32'(flush), 32'd0);
    repeat (EDGE_LAT) cycle();
    cycle();
    for (int i = 0; i < 3; i++) begin
      chk("t1_drain_flush", 32'(flush), 32'd1);
      chk("t1_drain_no_take", 32'(take_vector), 32'd0);
      cycle();
    end
    chk("t1_vector_flush_low", 32'(flush), 32'd0);
    wait_take("t1", n);
    chk("t1_take_latency", 32'(n), 32'd0);
    irq_src = 4'b0000;
    do_rti("t1");
    rti = 1'b1;
    #1;
    chk("t1_idle_rti_ignored", 32'(ret_take), 32'd0);
    cycle();
    rti = 1'b0;
    chk("t1_idle_rti_no_flush", 32'(flush), 32'd0);
    chk("t1_idle_rti_no_service", 32'(in_service), 32'd0);

    // Simultaneous sources 1 and 3: lowest wins, 3 taken back-to-back after rti
    epc_in = 32'h300;
    irq_src = 4'b1010;
    sb.push_back('{3'd1, 32'h410, 4'b0010, 32'h300});
    sb.push_back('{3'd3, 32'h430, 4'b1000, 32'h304});
    repeat (EDGE_LAT) cycle();
    cycle();
    wait_take("t2a", n);
    chk("t2a_take_latency", 32'(n), 32'd3);
    irq_src = 4'b1000;
    epc_in = 32'h304;
    do_rti("t2a");
    chk("t2_b2b_idle_flush", 32'(flush), 32'd0);
    cycle();
    chk("t2_b2b_drain_flush", 32'(flush), 32'd1);
    wait_take("t2b", n);
    chk("t2b_take_latency", 32'(n), 32'd3);
    irq_src = 4'b0000;
    do_rti("t2b");

    // Stall holds VECTOR for two cycles; epc is captured on the take cycle
    epc_in = 32'h500;
    stall = 1'b1;
    irq_src = 4'b0001;
    sb.push_back('{3'd0, 32'h400, 4'b0001, 32'h5A0});
    repeat (EDGE_LAT) cycle();
    repeat (4) cycle();
    for (int i = 0; i < 2; i++) begin
      chk("t3_stall_no_take", 32'(take_vector), 32'd0);
      chk("t3_stall_no_ack", 32'(irq_ack), 32'd0);
      chk("t3_stall_no_flush", 32'(flush), 32'd0);
      if (i == 0) cycle();
    end
    stall = 1'b0;
    epc_in = 32'h5A0;
    #1;
    wait_take("t3", n);
    chk("t3_take_latency", 32'(n), 32'd0);
    irq_src = 4'b0000;
    do_rti("t3");

    // Mask blocks acceptance; dropping it starts DRAIN; raising it mid-DRAIN does not abort
    global_mask = 1'b1;
    epc_in = 32'h600;
    irq_src = 4'b0100;
    for (int i = 0; i < 2 + EDGE_LAT; i++) begin
      cycle();
      chk("t4_masked_no_flush", 32'(flush), 32'd0);
    end
    global_mask = 1'b0;
    sb.push_back('{3'd2, 32'h420, 4'b0100, 32'h600});
    cycle();
    chk("t4_unmask_drain", 32'(flush), 32'd1);
    global_mask = 1'b1;
    irq_src = 4'b0000;
    repeat (2) cycle();
    chk("t4_committed_flush", 32'(flush), 32'd1);
    wait_take("t4", n);
    chk("t4_take_latency", 32'(n), 32'd1);
    global_mask = 1'b0;
    do_rti("t4");

    // Reset during DRAIN cycle 2 aborts; request re-accepted after release
    epc_in = 32'h700;
    irq_src = 4'b1000;
    repeat (EDGE_LAT) cycle();
    cycle();
    chk("t5_drain1", 32'(flush), 32'd1);
    cycle();
    rst_n = 1'b0;
    #1;
    chk("t5_rst_flush", 32'(flush), 32'd0);
    chk("t5_rst_take", 32'(take_vector), 32'd0);
    chk("t5_rst_ack", 32'(irq_ack), 32'd0);
    chk("t5_rst_service", 32'(in_service), 32'd0);
    chk("t5_rst_active_id", 32'(active_id), 32'd0);
    chk("t5_rst_vector_pc", vector_pc, 32'h400);
    chk("t5_rst_epc", epc_out, 32'd0);
    repeat (2) cycle();
    chk("t5_rst_hold_ack", 32'(irq_ack), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("t5_release_idle", 32'(flush), 32'd0);
    sb.push_back('{3'd3, 32'h430, 4'b1000, 32'h700});
    repeat (EDGE_LAT) cycle();
    cycle();
    chk("t5_reaccept", 32'(flush), 32'd1);
    wait_take("t5", n);
    chk("t5_take_latency", 32'(n), 32'd3);
    irq_src = 4'b0000;
    do_rti("t5");

`ifdef IRQ_EDGE_CAPTURE_EN
    // A pulse held high through SERVICE is acknowledged once and not re-taken
    epc_in = 32'h800;
    irq_src = 4'b0010;
    sb.push_back('{3'd1, 32'h410, 4'b0010, 32'h800});
    cycle();
    cycle();
    wait_take("t6", n);
    chk("t6_take_latency", 32'(n), 32'd3);
    do_rti("t6");
    for (int i = 0; i < 4; i++) begin
      chk("t6_no_retake", 32'(flush), 32'd0);
      cycle();
    end
    irq_src = 4'b0000;
`endif

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
